// File: rtl/s_load_ctrl_27.sv
// Serial-to-parallel frame loader with start/abort control
// and a hold-until-consumed output handshake.
module s_load_ctrl_27 #(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             sin,
  input  logic             bit_valid,
  input  logic             abort,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic             busy,
  output logic [4:0]       bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, shift datapath and registered flag decode
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          data_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else if (bit_valid) begin
          data_d = {data_q[WIDTH-2:0], sin};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == LAST) begin
            state_d = HOLD;
            busy_d  = 1'b0;
            valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (start) begin
            state_d = SHIFT;
            data_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign data      = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_s_load_ctrl_27.sv
// Directed bench for s_load_ctrl_27: frame capture, stall,
// abort, hold/back-to-back and mid-frame reset.
module tb_s_load_ctrl_27;

  localparam int W = 27;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic         sin;
  logic         bit_valid;
  logic         abort;
  logic         out_ready;
  logic [W-1:0] data;
  logic         out_valid;
  logic         busy;
  logic [4:0]   bit_cnt;

  int n_chk = 0;
  int n_err = 0;
  int edges = 0;

  logic [W-1:0] pat_a = 27'h5A5A5A5;
  logic [W-1:0] pat_b = 27'h1234567;
  logic [W-1:0] exp_d;

  s_load_ctrl_27 #(.WIDTH(W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .sin       (sin),
    .bit_valid (bit_valid),
    .abort     (abort),
    .out_ready (out_ready),
    .data      (data),
    .out_valid (out_valid),
    .busy      (busy),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic idle_in();
    start     = 1'b0;
    sin       = 1'b0;
    bit_valid = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
  endtask

  // send bits v[hi] down to v[lo], one per cycle
  task automatic send(input logic [W-1:0] v,
                      input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      sin       = v[i];
      bit_valid = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    sin       = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    edges = 0;
  endtask

  initial begin
    idle_in();
    n_rst = 1'b0;
    start = 1'b1;
    bit_valid = 1'b1;
    step();
    step();
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_cnt", 32'(bit_cnt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle_in();
    n_rst = 1'b1;
    step();

    // continuous frame
    do_start();
    chk("st_busy", 32'(busy), 32'd1);
    chk("st_cnt", 32'(bit_cnt), 32'd0);
    send(pat_a, 26, 1);
    chk("pre_valid", 32'(out_valid), 32'd0);
    chk("pre_cnt", 32'(bit_cnt), 32'd26);
    send(pat_a, 0, 0);
    chk("lat_edges", 32'(edges), 32'd27);
    chk("a_valid", 32'(out_valid), 32'd1);
    chk("a_data", 32'(data), 32'h5A5A5A5);
    chk("a_cnt", 32'(bit_cnt), 32'd27);
    chk("a_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rel_valid", 32'(out_valid), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);

    // stalled frame
    do_start();
    send(pat_a, 26, 16);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_cnt", 32'(bit_cnt), 32'd11);
    end
    exp_d = pat_a >> 16;
    chk("stall_data", 32'(data), 32'(exp_d));
    send(pat_a, 15, 0);
    chk("st_edges", 32'(edges), 32'd32);
    chk("st_valid", 32'(out_valid), 32'd1);
    chk("st_fdata", 32'(data), 32'h5A5A5A5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // abort after 13 bits
    do_start();
    send(pat_a, 26, 14);
    chk("ab_pre", 32'(bit_cnt), 32'd13);
    abort     = 1'b1;
    bit_valid = 1'b1;
    sin       = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_cnt", 32'(bit_cnt), 32'd0);
    chk("ab_data", 32'(data), 32'd0);
    chk("ab_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ab_idle_v", 32'(out_valid), 32'd0);
      chk("ab_idle_c", 32'(bit_cnt), 32'd0);
    end
    idle_in();
    do_start();
    send(pat_b, 26, 0);
    chk("b_valid", 32'(out_valid), 32'd1);
    chk("b_data", 32'(data), 32'h1234567);

    // hold with junk inputs, then back-to-back start
    for (int k = 0; k < 10; k++) begin
      abort     = k[0];
      bit_valid = 1'b1;
      sin       = ~k[0];
      start     = k[1];
      step();
      chk("hold_data", 32'(data), 32'h1234567);
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    idle_in();
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    idle_in();
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_cnt", 32'(bit_cnt), 32'd0);
    chk("b2b_valid", 32'(out_valid), 32'd0);
    chk("b2b_data", 32'(data), 32'd0);

    // reset mid-frame at 20 bits
    send(pat_a, 26, 7);
    chk("mr_pre", 32'(bit_cnt), 32'd20);
    n_rst     = 1'b0;
    bit_valid = 1'b1;
    step();
    n_rst = 1'b1;
    chk("mr_data", 32'(data), 32'd0);
    chk("mr_cnt", 32'(bit_cnt), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      sin = 1'b1;
      step();
      chk("mr_ign_cnt", 32'(bit_cnt), 32'd0);
      chk("mr_ign_data", 32'(data), 32'd0);
    end
    idle_in();
    do_start();
    send(pat_a, 26, 0);
    chk("mr_re_data", 32'(data), 32'h5A5A5A5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
